// File: rtl/game_ctrl_if.sv
// Phase-control bundle between the game sequencer and the fill, display and
// input phase blocks. The sequencer takes the master side.
interface game_ctrl_if;
    logic       start;
    logic       complete_IDLE;
    logic       complete_DISPLAY;
    logic       complete_INPUT;
    logic       input_correct;
    logic       en_IDLE;
    logic       rst_IDLE;
    logic       en_DISPLAY;
    logic       rst_DISPLAY;
    logic       en_INPUT;
    logic       rst_INPUT;
    logic [1:0] play_len;
    logic [2:0] score;
    logic       win;
    logic       lose;
    logic [2:0] state;

    modport master (
        input  start, complete_IDLE, complete_DISPLAY, complete_INPUT, input_correct,
        output en_IDLE, rst_IDLE, en_DISPLAY, rst_DISPLAY, en_INPUT, rst_INPUT,
        output play_len, score, win, lose, state
    );

    modport slave (
        output start, complete_IDLE, complete_DISPLAY, complete_INPUT, input_correct,
        input  en_IDLE, rst_IDLE, en_DISPLAY, rst_DISPLAY, en_INPUT, rst_INPUT,
        input  play_len, score, win, lose, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Phase sequencer for the memory-sequence game: fill -> (show -> play) per
// round -> win or lose, with per-phase reset/enable strobes, round and score
// tracking and a timed result display. Every output is a flop.
module game_ctrl #(
    parameter int MAX_ROUND   = 4,
    parameter int RESULT_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    game_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_FILL = 3'd1,
        S_SHOW = 3'd2,
        S_PLAY = 3'd3,
        S_WIN  = 3'd4,
        S_LOSE = 3'd5
    } state_e;

    localparam int         HOLD_W     = $clog2(RESULT_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(RESULT_HOLD - 1);
    localparam logic [1:0] LAST_ROUND = 2'(MAX_ROUND - 1);

    // Bit order of the strobe vectors: [0]=fill, [1]=display, [2]=input.
    state_e             state_q, state_d;
    logic               entry_q, entry_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         play_len_q, play_len_d;
    logic [2:0]         score_q, score_d;
    logic               start_q;
    logic [2:0]         en_q, en_d;
    logic [2:0]         rst_q, rst_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;

    logic               start_edge;
    assign start_edge = bus.start & ~start_q;

    // Next state, round/score bookkeeping and the registered output values.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        play_len_d = play_len_q;
        score_d    = score_q;
        hold_d     = hold_q;

        case (state_q)
            S_WAIT: begin
                if (start_edge) begin
                    play_len_d = 2'd0;
                    score_d    = 3'd0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (!entry_q && bus.complete_IDLE) state_d = S_SHOW;
            end
            S_SHOW: begin
                if (!entry_q && bus.complete_DISPLAY) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (!entry_q && bus.complete_INPUT) begin
                    if (bus.input_correct) begin
                        score_d = (score_q == 3'd7) ? score_q : score_q + 3'd1;
                        if (play_len_q == LAST_ROUND) begin
                            state_d = S_WIN;
                        end else begin
                            play_len_d = play_len_q + 2'd1;
                            state_d    = S_SHOW;
                        end
                    end else begin
                        state_d = S_LOSE;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (hold_q == '0) state_d = S_WAIT;
                else              hold_d  = hold_q - HOLD_W'(1);
            end
            default: state_d = S_WAIT;
        endcase

        // A state change means the next cycle is that state's entry cycle.
        entry_d = (state_d != state_q);
        if (entry_d && (state_d == S_WIN || state_d == S_LOSE)) hold_d = HOLD_INIT;

        en_d    = {(state_d == S_PLAY) && !entry_d,
                   (state_d == S_SHOW) && !entry_d,
                   (state_d == S_FILL) && !entry_d};
        rst_d   = ~en_d;
        win_d   = (state_d == S_WIN);
        lose_d  = (state_d == S_LOSE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= S_WAIT;
            entry_q    <= 1'b0;
            hold_q     <= '0;
            play_len_q <= 2'd0;
            score_q    <= 3'd0;
            start_q    <= 1'b1;  // a button held through reset is not an edge
            en_q       <= 3'b000;
            rst_q      <= 3'b111;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            hold_q     <= hold_d;
            play_len_q <= play_len_d;
            score_q    <= score_d;
            start_q    <= bus.start;
            en_q       <= en_d;
            rst_q      <= rst_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.play_len    = play_len_q;
    assign bus.score       = score_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;
    assign bus.en_IDLE     = en_q[0];
    assign bus.en_DISPLAY  = en_q[1];
    assign bus.en_INPUT    = en_q[2];
    assign bus.rst_IDLE    = rst_q[0];
    assign bus.rst_DISPLAY = rst_q[1];
    assign bus.rst_INPUT   = rst_q[2];

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: two instances (MAX_ROUND=4 and MAX_ROUND=1) share one
// stimulus; a phase/age reference model predicts every output each cycle, and
// directed scenarios pin the model with hand-computed expectations.
module tb_game_ctrl;

    localparam int HOLD = 16;

    logic clk;
    logic rst_n;
    logic start, c_idle, c_disp, c_inp, cor;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    game_ctrl_if g1 ();
    game_ctrl_if g2 ();

    assign g1.start = start;            assign g2.start = start;
    assign g1.complete_IDLE = c_idle;   assign g2.complete_IDLE = c_idle;
    assign g1.complete_DISPLAY = c_disp; assign g2.complete_DISPLAY = c_disp;
    assign g1.complete_INPUT = c_inp;   assign g2.complete_INPUT = c_inp;
    assign g1.input_correct = cor;      assign g2.input_correct = cor;

    game_ctrl #(.MAX_ROUND(4), .RESULT_HOLD(HOLD)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(g1));
    game_ctrl #(.MAX_ROUND(1), .RESULT_HOLD(HOLD)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(g2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current phase (0 wait,1 fill,2 show,3 play,4 win,5 lose)
    // and how many cycles it has been in that phase.
    typedef struct {
        int st;
        int age;
        int plen;
        int score;
        bit prev_start;
    } model_t;

    model_t m4, m1;

    function automatic model_t step(model_t m, int max_round, bit rn, bit st_in,
                                    bit ci, bit cd, bit cin, bit ok);
        model_t r = m;
        int nxt;
        if (!rn) begin
            r.st = 0; r.age = 0; r.plen = 0; r.score = 0; r.prev_start = 1'b1;
            return r;
        end
        nxt = m.st;
        case (m.st)
            0: if (st_in && !m.prev_start) begin r.plen = 0; r.score = 0; nxt = 1; end
            1: if (m.age > 0 && ci) nxt = 2;
            2: if (m.age > 0 && cd) nxt = 3;
            3: if (m.age > 0 && cin) begin
                if (ok) begin
                    r.score = (m.score + 1 > 7) ? 7 : m.score + 1;
                    if (m.plen + 1 == max_round) nxt = 4;
                    else begin r.plen = m.plen + 1; nxt = 2; end
                end else nxt = 5;
            end
            4, 5: if (m.age == HOLD - 1) nxt = 0;
            default: nxt = 0;
        endcase
        r.age = (nxt != m.st) ? 0 : m.age + 1;
        r.st = nxt;
        r.prev_start = st_in;
        return r;
    endfunction

    function automatic logic [15:0] expv(model_t m);
        logic [2:0] en;
        en = {m.st == 3 && m.age > 0, m.st == 2 && m.age > 0, m.st == 1 && m.age > 0};
        return {3'(m.st), en, ~en, 2'(m.plen), 3'(m.score), m.st == 4, m.st == 5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        m4 <= step(m4, 4, rst_n, start, c_idle, c_disp, c_inp, cor);
        m1 <= step(m1, 1, rst_n, start, c_idle, c_disp, c_inp, cor);
    end

    // Every-cycle comparison of all outputs, half a cycle after the edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("dut4_outputs", {g1.state, g1.en_INPUT, g1.en_DISPLAY, g1.en_IDLE,
                  g1.rst_INPUT, g1.rst_DISPLAY, g1.rst_IDLE, g1.play_len, g1.score,
                  g1.win, g1.lose}, 32'(expv(m4)));
            check("dut1_outputs", {g2.state, g2.en_INPUT, g2.en_DISPLAY, g2.en_IDLE,
                  g2.rst_INPUT, g2.rst_DISPLAY, g2.rst_IDLE, g2.play_len, g2.score,
                  g2.win, g2.lose}, 32'(expv(m1)));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic bit g1_en(input int ph);
        case (ph)
            1:       return g1.en_IDLE;
            2:       return g1.en_DISPLAY;
            default: return g1.en_INPUT;
        endcase
    endfunction

    // Wait (bounded) for the phase enable, then pulse its complete for one cycle.
    task automatic pulse(input int ph, input bit ok);
        int n = 0;
        while (!g1_en(ph) && n < 60) begin cyc(); n++; end
        check($sformatf("en_seen_ph%0d", ph), 32'(g1_en(ph)), 32'd1);
        case (ph)
            1:       c_idle = 1'b1;
            2:       c_disp = 1'b1;
            default: begin c_inp = 1'b1; cor = ok; end
        endcase
        cyc();
        c_idle = 1'b0; c_disp = 1'b0; c_inp = 1'b0;
    endtask

    task automatic count_result(input string name, input bit is_win);
        int n = 0;
        while ((is_win ? g1.win : g1.lose) && n < 40) begin n++; cyc(); end
        check(name, n, HOLD);
        check({name, "_then_wait"}, 32'(g1.state), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1;
        c_idle = 1'b0; c_disp = 1'b0; c_inp = 1'b0; cor = 1'b0;

        // Reset with start held across release.
        cyc();
        cmp_en = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        check("held_start_state", 32'(g1.state), 32'd0);
        check("held_start_rst", {g1.rst_INPUT, g1.rst_DISPLAY, g1.rst_IDLE}, 32'd7);
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        check("start_fill_state", 32'(g1.state), 32'd1);
        check("fill_entry_rst", 32'(g1.rst_IDLE), 32'd1);
        check("fill_entry_en", 32'(g1.en_IDLE), 32'd0);
        cyc();
        check("fill_en", 32'(g1.en_IDLE), 32'd1);
        check("fill_rst_low", 32'(g1.rst_IDLE), 32'd0);

        // Full win with MAX_ROUND=4; the MAX_ROUND=1 instance wins after round 0.
        pulse(1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("round%0d_play_len", r), 32'(g1.play_len), r);
            pulse(2, 1'b0);
            pulse(3, 1'b1);
            if (r == 0) begin
                check("max1_win_state", 32'(g2.state), 32'd4);
                check("max1_play_len", 32'(g2.play_len), 32'd0);
                check("max1_score", 32'(g2.score), 32'd1);
            end
        end
        check("win_state", 32'(g1.state), 32'd4);
        check("win_score", 32'(g1.score), 32'd4);
        check("win_play_len", 32'(g1.play_len), 32'd3);
        count_result("win_cycles", 1'b1);

        // Loss in round 2 with stray completes during SHOW.
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        check("restart_fill", 32'(g1.state), 32'd1);
        pulse(1, 1'b0);
        pulse(2, 1'b0);
        pulse(3, 1'b1);
        check("show_entry_rst", 32'(g1.rst_DISPLAY), 32'd1);
        c_disp = 1'b1; c_inp = 1'b1;
        cyc();
        c_disp = 1'b0;
        check("show_entry_complete_ignored", 32'(g1.state), 32'd2);
        cyc();
        check("stray_input_in_show", 32'(g1.state), 32'd2);
        c_inp = 1'b0;
        pulse(2, 1'b0);
        pulse(3, 1'b0);
        check("lose_state", 32'(g1.state), 32'd5);
        check("lose_flag", 32'(g1.lose), 32'd1);
        check("lose_score", 32'(g1.score), 32'd1);
        check("lose_play_len", 32'(g1.play_len), 32'd1);
        count_result("lose_cycles", 1'b0);

        // One-cycle reset in the middle of round-2 PLAY.
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        pulse(1, 1'b0);
        pulse(2, 1'b0);
        pulse(3, 1'b1);
        pulse(2, 1'b0);
        begin
            int n = 0;
            while (!g1.en_INPUT && n < 60) begin cyc(); n++; end
        end
        cyc();
        rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        check("midplay_reset_state", 32'(g1.state), 32'd0);
        check("midplay_reset_en", {g1.en_INPUT, g1.en_DISPLAY, g1.en_IDLE}, 32'd0);
        check("midplay_reset_rst", {g1.rst_INPUT, g1.rst_DISPLAY, g1.rst_IDLE}, 32'd7);
        check("midplay_reset_play_len", 32'(g1.play_len), 32'd0);
        check("midplay_reset_score", 32'(g1.score), 32'd0);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom % 4 == 0) start = ~start;
            c_idle = ($urandom % 3 == 0);
            c_disp = ($urandom % 3 == 0);
            c_inp  = ($urandom % 3 == 0);
            cor    = ($urandom % 5 != 0);
            rst_n  = ($urandom % 300 != 0);
            cyc();
        end
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level phase sequencer for the memory-sequence game. It drives the fill phase (LFSR values loaded into the 4-entry pattern memory), the display phase and the player-input phase in order. It issues per-phase reset and enable strobes, tracks the round (current sequence length) and score, and signals win or lose. It is the only block that asserts the sub-block `en_*`/`rst_*` lines.

## Interface
- `MAX_ROUND`, default 4: rounds needed to win, range 1..4 (bounded by memory depth).
- `RESULT_HOLD`, default 16: cycles the win/lose result is held before returning to wait, range ≥1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  player start button, synchronous level.
- `complete_IDLE`  in  1  fill phase done.
- `complete_DISPLAY`  in  1  display phase done.
- `complete_INPUT`  in  1  input phase done.
- `input_correct`  in  1  input verdict, qualified by `complete_INPUT`.
- `en_IDLE` / `rst_IDLE`  out  1 each  fill phase enable and reset (reset active-high).
- `en_DISPLAY` / `rst_DISPLAY`  out  1 each  display phase enable and reset.
- `en_INPUT` / `rst_INPUT`  out  1 each  input phase enable and reset.
- `play_len`  out  2  current round index; entries 0..`play_len` are shown and checked.
- `score`  out  3  rounds passed this game.
- `win`, `lose`  out  1 each  result flags.
- `state`  out  3  encoded FSM state, for debug and LEDs.

## Operation
- States and encodings: WAIT=0, FILL=1, SHOW=2, PLAY=3, WIN=4, LOSE=5. Codes 6 and 7 are unreachable; if entered, go to WAIT next cycle.
- Reset (`rst_n`=0):
  - state WAIT.
  - All `en_*`=0, all `rst_*`=1.
  - `play_len`=0, `score`=0, `win`=`lose`=0.
  - `start_q`=1, so a button already held at reset release is not accepted.
- Start edge detect: `start_q` is a register of `start`. A start is accepted only in WAIT, only when `start & ~start_q`. All other starts are ignored.
- Phase entry protocol for FILL, SHOW and PLAY:
  - First cycle in the state is the entry cycle: that phase's `rst_*`=1, `en_*`=0.
  - Following cycles: `rst_*`=0, `en_*`=1 until the phase's `complete_*` is sampled high.
  - While a phase is not active, its `rst_*` is held at 1 and its `en_*` at 0.
- WAIT: all `rst_*`=1, `en_*`=0, `win`=`lose`=0. On an accepted start, clear `play_len` and `score`, then go to FILL.
- FILL: on `complete_IDLE`, go to SHOW.
- SHOW: on `complete_DISPLAY`, go to PLAY.
- PLAY, on `complete_INPUT` with `input_correct`=1:
  - `score` increments.
  - If `play_len`==`MAX_ROUND`-1, go to WIN.
  - Otherwise `play_len` increments and the FSM goes to SHOW.
- PLAY, on `complete_INPUT` with `input_correct`=0: go to LOSE. `score` and `play_len` are unchanged.
- WIN/LOSE:
  - `win` (or `lose`) =1 throughout the state.
  - Hold counter loads `RESULT_HOLD`-1 on entry and decrements each cycle.
  - When the counter reads 0, go to WAIT.
  - `play_len` and `score` stay frozen until the next accepted start.
- Ignored inputs:
  - A `complete_*` from a phase that is not the current state.
  - Any `complete_*` sampled during an entry cycle.
  - `input_correct` when `complete_INPUT`=0.
- Counter and arithmetic rules:
  - `score` saturates at 7.
  - `play_len` never exceeds `MAX_ROUND`-1, so there is no wrap.
  - Hold counter width is `$clog2(RESULT_HOLD+1)`.

## Timing
- All outputs are registered. `state`, `en_*`, `rst_*`, `win` and `lose` change together on the edge after the deciding input is sampled.
- Accepted start sampled at edge N:
  - Edge N+1: state=FILL, `rst_IDLE`=1, `en_IDLE`=0.
  - Edge N+2: `en_IDLE`=1.
- `complete_X` sampled high at edge M: next state is entered at M+1 with its entry cycle. The next phase's enable rises at M+2.
- Minimum latency from `complete_*` to next phase enable: 2 cycles.
- WIN/LOSE lasts exactly `RESULT_HOLD` cycles, then WAIT. `start` held through the result is not accepted until it drops and rises again.
- Reset mid-operation (any state, any cycle): the next edge produces the reset values above. There is no partial-phase completion.

## Test plan
- Reset, then start held high across reset release: FSM stays in WAIT with all `rst_*`=1. Lower then raise `start`: `state`=1 one cycle later, `rst_IDLE`=1 for exactly 1 cycle, then `en_IDLE`=1.
- Full win, `MAX_ROUND`=4, all phases completing with `input_correct`=1:
  - Sequence is FILL → SHOW/PLAY four times → WIN.
  - `play_len` steps 0,1,2,3; `score`=4 in WIN.
  - `win`=1 for exactly 16 cycles, then `state`=0.
- Loss in round 2 (`input_correct`=0 while `play_len`=1): `state`=5, `lose`=1, `score`=1, `play_len`=1 held through 16 hold cycles, then WAIT.
- Stray completes:
  - `complete_INPUT`=1 during SHOW: no state change.
  - `complete_DISPLAY` during a SHOW entry cycle: ignored; the FSM stays in SHOW until a later `complete_DISPLAY`.
- `rst_n` low for 1 cycle in the middle of PLAY: next cycle `state`=0, all `en_*`=0, all `rst_*`=1, `play_len`=0, `score`=0.
- `MAX_ROUND`=1: one correct input after the first SHOW/PLAY goes directly to WIN with `play_len`=0 and `score`=1.
